// File: rtl/bus_demux_bridge.sv
// bus_demux_bridge
// Routes a single CPU data-memory request to one of three memory-mapped
// slaves (DMEM, I/O registers, timer) selected by address bits [31:28].
// The request, address, write data and slave select are registered in IDLE.
// The chosen slave then sees a held one-hot request until it acks or the
// access times out. Completion is a one-cycle m_ready pulse, qualified by
// m_err for decode errors and timeouts.
module bus_demux_bridge #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15   // ACCESS cycles without ack before error, 1..255
) (
   input  logic             clk,
   input  logic             rst_n,
   // master side
   input  logic             m_req,
   input  logic             m_we,
   input  logic [31:0]      m_addr,
   input  logic [WIDTH-1:0] m_wdata,
   output logic [WIDTH-1:0] m_rdata,
   output logic             m_ready,
   output logic             m_err,
   output logic             m_busy,
   // slave side
   output logic [2:0]       s_req,
   output logic             s_we,
   output logic [31:0]      s_addr,
   output logic [WIDTH-1:0] s_wdata,
   input  logic [WIDTH-1:0] s_rdata0,
   input  logic [WIDTH-1:0] s_rdata1,
   input  logic [WIDTH-1:0] s_rdata2,
   input  logic [2:0]       s_ack
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   // Value of the ACCESS cycle counter on the last cycle before a timeout.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t           state;
   state_t           state_next;

   logic [1:0]       sel;          // latched slave index, valid in ACCESS
   logic [7:0]       count;        // ACCESS cycles elapsed for this access

   logic [1:0]       dec_sel;      // slave index decoded from the live m_addr
   logic             dec_ok;       // m_addr maps onto an existing slave
   logic [2:0]       sel_onehot;   // one-hot form of the latched select
   logic             ack_sel;      // ack from the selected slave only
   logic [WIDTH-1:0] rdata_sel;    // read data from the selected slave only
   logic             timeout_hit;  // last ACCESS cycle allowed without ack

   // Address decode of the incoming request; bits [31:28] pick the slave.
   always_comb begin
      // NOTE: every signal assigned in a combinational block receives a default
      // first, so no path leaves it unassigned and no latch is inferred.
      dec_sel = 2'd0;
      dec_ok  = 1'b0;
      case (m_addr[31:28])
         4'h0: begin
            dec_sel = 2'd0;
            dec_ok  = 1'b1;
         end
         4'h1: begin
            dec_sel = 2'd1;
            dec_ok  = 1'b1;
         end
         4'h2: begin
            dec_sel = 2'd2;
            dec_ok  = 1'b1;
         end
         default: begin
            dec_sel = 2'd0;
            dec_ok  = 1'b0;
         end
      endcase
   end

   // Steer ack and read data from the latched slave; other slaves are ignored.
   always_comb begin
      sel_onehot = 3'b000;
      ack_sel    = 1'b0;
      rdata_sel  = '0;
      case (sel)
         2'd0: begin
            sel_onehot = 3'b001;
            ack_sel    = s_ack[0];
            rdata_sel  = s_rdata0;
         end
         2'd1: begin
            sel_onehot = 3'b010;
            ack_sel    = s_ack[1];
            rdata_sel  = s_rdata1;
         end
         2'd2: begin
            sel_onehot = 3'b100;
            ack_sel    = s_ack[2];
            rdata_sel  = s_rdata2;
         end
         default: begin
            sel_onehot = 3'b000;
            ack_sel    = 1'b0;
            rdata_sel  = '0;
         end
      endcase
   end

   assign timeout_hit = (count == CNT_LAST);

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: clocked state is always updated with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_next = state;
      m_ready    = 1'b0;
      m_err      = 1'b0;
      m_busy     = 1'b1;
      s_req      = 3'b000;
      case (state)
         IDLE: begin
            m_busy = 1'b0;
            if (m_req) begin
               state_next = dec_ok ? ACCESS : ERR;
            end
         end
         ACCESS: begin
            s_req = sel_onehot;
            // An ack on the final allowed cycle still completes normally.
            if (ack_sel) begin
               state_next = DONE;
            end else if (timeout_hit) begin
               state_next = ERR;
            end
         end
         DONE: begin
            m_ready    = 1'b1;
            state_next = IDLE;
         end
         ERR: begin
            m_ready    = 1'b1;
            m_err      = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request latch, access counter and completion read-data register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel     <= 2'd0;
         count   <= 8'd0;
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         m_rdata <= '0;
      end else begin
         // Capture the request only in IDLE; m_req while busy is dropped.
         if (state == IDLE && m_req) begin
            sel     <= dec_sel;
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            count   <= 8'd0;
         end else if (state == ACCESS) begin
            count <= count + 8'd1;
         end

         // m_rdata changes only on completion and holds until the next one.
         if (state_next == ERR) begin
            m_rdata <= '0;
         end else if (state == ACCESS && state_next == DONE) begin
            m_rdata <= s_we ? '0 : rdata_sel;
         end
      end
   end

endmodule

// File: tb/tb_bus_demux_bridge.sv
// tb_bus_demux_bridge
// Transaction-level self-checking bench. Each access is predicted from the
// address map and the chosen ack delay: which one-hot request is shown, for
// how many cycles, whether it completes with an error, and the read data
// returned. Inputs are driven and outputs sampled on the falling edge.
module tb_bus_demux_bridge;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 15;
   localparam int NEVER   = 1000;   // ack delay meaning "slave never acks"

   logic             clk;
   logic             rst_n;
   logic             m_req;
   logic             m_we;
   logic [31:0]      m_addr;
   logic [WIDTH-1:0] m_wdata;
   logic [WIDTH-1:0] m_rdata;
   logic             m_ready;
   logic             m_err;
   logic             m_busy;
   logic [2:0]       s_req;
   logic             s_we;
   logic [31:0]      s_addr;
   logic [WIDTH-1:0] s_wdata;
   logic [WIDTH-1:0] s_rdata0;
   logic [WIDTH-1:0] s_rdata1;
   logic [WIDTH-1:0] s_rdata2;
   logic [2:0]       s_ack;

   int total = 0;
   int bad   = 0;

   // Read data the master should currently see (last completion or reset).
   logic [31:0] exp_rdata = 32'd0;

   bus_demux_bridge #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata),
      .m_ready  (m_ready),
      .m_err    (m_err),
      .m_busy   (m_busy),
      .s_req    (s_req),
      .s_we     (s_we),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_rdata0 (s_rdata0),
      .s_rdata1 (s_rdata1),
      .s_rdata2 (s_rdata2),
      .s_ack    (s_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // Every output of the bridge must read as zero.
   task automatic check_all_zero(input string tag);
      check({tag, "_rdata"}, 64'(m_rdata), 64'd0);
      check({tag, "_ready"}, 64'(m_ready), 64'd0);
      check({tag, "_err"},   64'(m_err),   64'd0);
      check({tag, "_busy"},  64'(m_busy),  64'd0);
      check({tag, "_sreq"},  64'(s_req),   64'd0);
      check({tag, "_swe"},   64'(s_we),    64'd0);
      check({tag, "_saddr"}, 64'(s_addr),  64'd0);
      check({tag, "_swdat"}, 64'(s_wdata), 64'd0);
   endtask

   // One complete access, entered and left just after a falling edge in IDLE.
   // ack_delay = ACCESS cycle index (0-based) on which the slave acks;
   // NEVER or any value >= TIMEOUT means the slave stays silent.
   task automatic run_access(input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input int ack_delay,
                             input logic [31:0] rd_val, input bit noise);
      int          slave;
      int          n_cycles;
      logic [2:0]  onehot;
      logic        exp_err;
      slave   = int'(addr[31:28]);
      m_req   = 1'b1;
      m_we    = we;
      m_addr  = addr;
      m_wdata = wdata;
      @(negedge clk);
      m_req = 1'b0;
      if (slave > 2) begin
         // Unmapped address: error completion one cycle after the request.
         exp_rdata = 32'd0;
         check("dec_ready", 64'(m_ready), 64'd1);
         check("dec_err",   64'(m_err),   64'd1);
         check("dec_rdata", 64'(m_rdata), 64'(exp_rdata));
         check("dec_sreq",  64'(s_req),   64'd0);
         check("dec_busy",  64'(m_busy),  64'd1);
      end else begin
         onehot   = 3'(1 << slave);
         exp_err  = (ack_delay >= TIMEOUT);
         n_cycles = exp_err ? TIMEOUT : ack_delay + 1;
         for (int k = 0; k < n_cycles; k++) begin
            check("acc_sreq",  64'(s_req),   64'(onehot));
            check("acc_ready", 64'(m_ready), 64'd0);
            check("acc_busy",  64'(m_busy),  64'd1);
            check("acc_hold",  64'(m_rdata), 64'(exp_rdata));
            check("acc_saddr", 64'(s_addr),  64'(addr));
            check("acc_swe",   64'(s_we),    64'(we));
            check("acc_swdat", 64'(s_wdata), 64'(wdata));
            s_rdata0 = $urandom;
            s_rdata1 = $urandom;
            s_rdata2 = $urandom;
            if (noise) begin
               m_req   = 1'($urandom);
               m_we    = 1'($urandom);
               m_addr  = $urandom;
               m_wdata = $urandom;
               s_ack   = 3'($urandom) & ~onehot;
            end else begin
               s_ack = 3'b000;
            end
            if (!exp_err && k == ack_delay) begin
               s_ack = s_ack | onehot;
               case (slave)
                  0:       s_rdata0 = rd_val;
                  1:       s_rdata1 = rd_val;
                  default: s_rdata2 = rd_val;
               endcase
            end
            @(negedge clk);
         end
         s_ack = 3'b000;
         m_req = 1'b0;
         exp_rdata = (exp_err || we) ? 32'd0 : rd_val;
         check("done_ready", 64'(m_ready), 64'd1);
         check("done_err",   64'(m_err),   64'(exp_err));
         check("done_rdata", 64'(m_rdata), 64'(exp_rdata));
         check("done_sreq",  64'(s_req),   64'd0);
         check("done_busy",  64'(m_busy),  64'd1);
      end
      @(negedge clk);
      check("idle_ready", 64'(m_ready), 64'd0);
      check("idle_err",   64'(m_err),   64'd0);
      check("idle_busy",  64'(m_busy),  64'd0);
      check("idle_sreq",  64'(s_req),   64'd0);
      check("idle_rdata", 64'(m_rdata), 64'(exp_rdata));
   endtask

   // Global time limit so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] addr;
      logic [3:0]  top;
      int          dly;

      rst_n    = 1'b0;
      m_req    = 1'b0;
      m_we     = 1'b0;
      m_addr   = 32'd0;
      m_wdata  = 32'd0;
      s_rdata0 = 32'd0;
      s_rdata1 = 32'd0;
      s_rdata2 = 32'd0;
      s_ack    = 3'b000;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Minimum-latency read from slave 1.
      run_access(32'h1000_0010, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
      // Write to slave 0 with a 4-cycle ack delay: request held 5 cycles.
      run_access(32'h0000_0004, 1'b1, 32'h1234_5678, 4, 32'hFFFF_FFFF, 1'b0);
      // Unmapped address.
      run_access(32'h3000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
      // Give m_rdata a non-zero value, then time out on slave 2.
      run_access(32'h2000_0008, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
      run_access(32'h2000_0008, 1'b0, 32'h0, NEVER, 32'h0, 1'b0);
      // Ack on the last allowed cycle still completes without error.
      run_access(32'h2000_000C, 1'b0, 32'h0, TIMEOUT - 1, 32'h0BAD_CAFE, 1'b0);
      // Stray m_req and acks on unselected slaves during ACCESS.
      run_access(32'h2000_0100, 1'b0, 32'h0, 6, 32'h5A5A_A5A5, 1'b1);
      run_access(32'h0000_0200, 1'b0, 32'h0, 3, 32'h1357_9BDF, 1'b1);

      // Reset in the middle of an access: everything clears, no m_ready.
      m_req   = 1'b1;
      m_we    = 1'b1;
      m_addr  = 32'h2000_0040;
      m_wdata = 32'hA5A5_0000;
      @(negedge clk);
      m_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("mid_sreq", 64'(s_req), 64'b100);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("mid_reset");
      exp_rdata = 32'd0;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_mid_ready", 64'(m_ready), 64'd0);
         check("post_mid_busy",  64'(m_busy),  64'd0);
      end

      // Randomized back-to-back traffic.
      for (int n = 0; n < 120; n++) begin
         top  = 4'($urandom_range(0, 5));
         if (top == 4'd5) top = 4'($urandom_range(3, 15));
         addr = {top, 28'($urandom)};
         case ($urandom_range(0, 9))
            0:       dly = NEVER;
            1:       dly = TIMEOUT - 1;
            2:       dly = TIMEOUT;
            default: dly = $urandom_range(0, 5);
         endcase
         run_access(addr, 1'($urandom), $urandom, dly, $urandom, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
